fp_compare_pipe: RTL and testbench

FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

---
 rtl/fp_cmp_pkg.sv | 51 +++++
 rtl/fp_cmp_lane.sv | 50 +++++
 rtl/fp_compare_pipe.sv | 142 ++++++++++++++
 tb/tb_fp_compare_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the FloPoCo floating-point compare pipeline:
// exception codes, compare op encodings, ordering categories and the
// maximum supported pipeline latency.
package fp_cmp_pkg;

    localparam int unsigned MAX_LAT = 8;

    // FloPoCo exception field, top two bits of every operand.
    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_e;

    // Compare modes carried on the op port; 110/111 are reserved.
    typedef enum logic [2:0] {
        OP_LT = 3'b000,
        OP_LE = 3'b001,
        OP_EQ = 3'b010,
        OP_GE = 3'b011,
        OP_GT = 3'b100,
        OP_NE = 3'b101
    } op_e;

    // Coarse ordering rank of an operand. Ranks increase with value, so two
    // operands in different ranks are ordered by rank alone; NaN sits outside
    // the order and is only used to raise unord.
    typedef enum logic [2:0] {
        CAT_NEG_INF  = 3'd0,
        CAT_NEG_NORM = 3'd1,
        CAT_ZERO     = 3'd2,
        CAT_POS_NORM = 3'd3,
        CAT_POS_INF  = 3'd4,
        CAT_NAN      = 3'd5
    } cat_e;

    // Map exception code and sign to an ordering rank. Sign is ignored for
    // zero (so +0 == -0) and for NaN.
    function automatic cat_e classify(input exc_e exc, input logic sign);
        cat_e cat;
        case (exc)
            EXC_ZERO:   cat = CAT_ZERO;
            EXC_NORMAL: cat = sign ? CAT_NEG_NORM : CAT_POS_NORM;
            EXC_INF:    cat = sign ? CAT_NEG_INF : CAT_POS_INF;
            default:    cat = CAT_NAN;
        endcase
        return cat;
    endfunction

endpackage

// File: rtl/fp_cmp_lane.sv
// One comparison lane: classifies both FloPoCo operands and produces the
// lt / eq / unord intermediates combinationally. No subtractor is used:
// ordering is by rank first, then by raw {exponent,fraction} magnitude.
module fp_cmp_lane
    import fp_cmp_pkg::*;
#(
    parameter int unsigned WE = 11,
    parameter int unsigned WF = 52,
    localparam int unsigned W = WE + WF + 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         unord
);

    cat_e                 cat_a;
    cat_e                 cat_b;
    logic [WE+WF-1:0]     mag_a;
    logic [WE+WF-1:0]     mag_b;

    assign cat_a = classify(exc_e'(a[W-1:W-2]), a[W-3]);
    assign cat_b = classify(exc_e'(b[W-1:W-2]), b[W-3]);
    assign mag_a = a[WE+WF-1:0];
    assign mag_b = b[WE+WF-1:0];

    // Rank compare, falling back to magnitude for two normals of equal sign.
    always_comb begin
        lt    = 1'b0;
        eq    = 1'b0;
        unord = (cat_a == CAT_NAN) || (cat_b == CAT_NAN);
        if (!unord) begin
            if (cat_a != cat_b) begin
                lt = (cat_a < cat_b);
            end else if (cat_a == CAT_POS_NORM) begin
                lt = (mag_a < mag_b);
                eq = (mag_a == mag_b);
            end else if (cat_a == CAT_NEG_NORM) begin
                // Larger magnitude is the smaller value when negative.
                lt = (mag_a > mag_b);
                eq = (mag_a == mag_b);
            end else begin
                // Both zero, or both infinity of the same sign.
                eq = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined multi-lane FloPoCo floating-point comparator.
// Stage 1 registers the per-lane lt/eq/unord intermediates with op, stages
// 2..LAT-1 delay them, and the output stage registers the op decode, giving
// exactly LAT cycles from in_valid to out_valid. LAT must be 1..MAX_LAT.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int unsigned WE    = 11,
    parameter int unsigned WF    = 52,
    parameter int unsigned LANES = 1,
    parameter int unsigned LAT   = 2,
    localparam int unsigned W    = WE + WF + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [2:0]           op,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    output logic                 out_valid,
    output logic [LANES-1:0]     res,
    output logic [LANES-1:0]     unord
);

    typedef struct packed {
        logic [2:0]       op;
        logic [LANES-1:0] lt;
        logic [LANES-1:0] eq;
        logic [LANES-1:0] un;
    } stage_t;

    logic [LANES-1:0] lt_c;
    logic [LANES-1:0] eq_c;
    logic [LANES-1:0] un_c;
    stage_t           st_c;

    logic             dec_v;
    stage_t           dec;
    logic [LANES-1:0] res_d;
    logic             load_out;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_cmp_lane #(
            .WE(WE),
            .WF(WF)
        ) u_lane (
            .a    (in_a[i*W +: W]),
            .b    (in_b[i*W +: W]),
            .lt   (lt_c[i]),
            .eq   (eq_c[i]),
            .unord(un_c[i])
        );
    end

    // Bundle the combinational lane results with op for the pipeline.
    always_comb begin
        st_c    = '0;
        st_c.op = op;
        st_c.lt = lt_c;
        st_c.eq = eq_c;
        st_c.un = un_c;
    end

    if (LAT > 1) begin : g_pipe
        localparam int unsigned D = LAT - 1;

        logic   v_q  [1:D];
        stage_t st_q [1:D];

        // Stage 1 valid: a flush in the same cycle drops the incoming input.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q[1] <= 1'b0;
            end else begin
                v_q[1] <= in_valid & ~flush;
            end
        end

        // Stage 1 data: intermediates are captured every cycle; valid qualifies them.
        always_ff @(posedge clk) begin
            st_q[1] <= st_c;
        end

        for (genvar s = 2; s <= D; s++) begin : g_stage
            // Delay-stage valid, cleared by reset or flush.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q[s] <= 1'b0;
                end else begin
                    v_q[s] <= v_q[s-1] & ~flush;
                end
            end

            // Delay-stage data, no reset needed.
            always_ff @(posedge clk) begin
                st_q[s] <= st_q[s-1];
            end
        end

        assign dec_v = v_q[D];
        assign dec   = st_q[D];
    end else begin : g_direct
        // With LAT=1 the output stage is the only register, so decode straight
        // from the lanes.
        assign dec_v = in_valid;
        assign dec   = st_c;
    end

    // Op decode, vectorised across lanes. The lanes force lt=eq=0 on NaN, so
    // NE alone yields 1 for unordered operands; reserved codes yield 0.
    always_comb begin
        res_d = '0;
        case (dec.op)
            OP_LT:   res_d = dec.lt;
            OP_LE:   res_d = dec.lt | dec.eq;
            OP_EQ:   res_d = dec.eq;
            OP_GE:   res_d = ~dec.lt & ~dec.un;
            OP_GT:   res_d = ~(dec.lt | dec.eq | dec.un);
            OP_NE:   res_d = ~dec.eq;
            default: res_d = '0;
        endcase
    end

    assign load_out = dec_v & ~flush;

    // Output stage: results update only with a valid transaction, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            unord     <= '0;
        end else begin
            out_valid <= load_out;
            if (load_out) begin
                res   <= res_d;
                unord <= dec.un;
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: a 1-lane LAT=2 instance for directed
// cases and a 4-lane LAT=3 instance for random traffic, flush and reset.
// Expected results come from a value-key reference model.
module tb_fp_compare_pipe;

    localparam int unsigned WE   = 11;
    localparam int unsigned WF   = 52;
    localparam int unsigned W    = WE + WF + 3;
    localparam int unsigned LAT1 = 2;
    localparam int unsigned LAT4 = 3;

    localparam logic [2:0] C_LT = 3'b000;
    localparam logic [2:0] C_LE = 3'b001;
    localparam logic [2:0] C_EQ = 3'b010;
    localparam logic [2:0] C_GE = 3'b011;
    localparam logic [2:0] C_GT = 3'b100;
    localparam logic [2:0] C_NE = 3'b101;

    logic           clk = 1'b0;
    logic           rst = 1'b0;

    logic           flush1, in_valid1, out_valid1, res1, unord1;
    logic [2:0]     op1;
    logic [W-1:0]   a1, b1;

    logic           flush4, in_valid4, out_valid4;
    logic [2:0]     op4;
    logic [4*W-1:0] a4, b4;
    logic [3:0]     res4, unord4;

    typedef struct {
        int         due;
        logic [3:0] r;
        logic [3:0] u;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       last1_r = 1'b0, last1_u = 1'b0;
    logic [3:0] last4_r = '0,   last4_u = '0;

    fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(1), .LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .op(op1),
        .in_a(a1), .in_b(b1), .out_valid(out_valid1), .res(res1), .unord(unord1)
    );

    fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(4), .LAT(LAT4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .op(op4),
        .in_a(a4), .in_b(b4), .out_valid(out_valid4), .res(res4), .unord(unord4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                        input logic [10:0] e, input logic [51:0] f);
        return {exc, s, e, f};
    endfunction

    function automatic logic [W-1:0] from_real(input real r);
        logic [63:0] bits;
        bits = $realtobits(r);
        if (r == 0.0) return {2'b00, bits[63], 63'd0};
        return {2'b01, bits};
    endfunction

    // Signed integer that grows with the operand's value; zero of either sign is 0.
    function automatic logic signed [66:0] key(input logic [W-1:0] x);
        logic signed [66:0] k;
        case (x[W-1:W-2])
            2'b00:   k = '0;
            2'b01:   k = $signed({4'b0000, x[62:0]}) + 67'sd1;
            default: k = (67'sd1 <<< 63) + 67'sd1;
        endcase
        if (x[W-1:W-2] != 2'b00 && x[W-3]) k = -k;
        return k;
    endfunction

    function automatic void ref_cmp(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic r, output logic u);
        logic signed [66:0] ka, kb;
        u  = (a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11);
        ka = key(a);
        kb = key(b);
        if (u) r = (op == C_NE);
        else begin
            case (op)
                C_LT:    r = (ka <  kb);
                C_LE:    r = (ka <= kb);
                C_EQ:    r = (ka == kb);
                C_GE:    r = (ka >= kb);
                C_GT:    r = (ka >  kb);
                C_NE:    r = (ka != kb);
                default: r = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        int unsigned k;
        logic [63:0] m;
        logic [1:0]  exc;
        k = $urandom_range(0, 9);
        m = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) m[62:52] = 11'd1023 + 11'($urandom_range(0, 1));
        exc = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
        return {exc, m};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drv1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic er, input logic eu);
        exp_t e;
        in_valid1 = 1'b1; op1 = op; a1 = a; b1 = b;
        if (push) begin
            e.due = cyc + LAT1; e.r = {3'b000, er}; e.u = {3'b000, eu};
            sb1.push_back(e);
        end
        tick();
        in_valid1 = 1'b0;
    endtask

    task automatic drv1_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic r, u;
        ref_cmp(op, a, b, r, u);
        drv1(op, a, b, 1'b1, r, u);
    endtask

    task automatic drv4(input logic [2:0] op, input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                        input bit push);
        exp_t e;
        logic r, u;
        in_valid4 = 1'b1; op4 = op; a4 = a; b4 = b;
        if (push) begin
            e.due = cyc + LAT4;
            for (int i = 0; i < 4; i++) begin
                ref_cmp(op, a[i*W +: W], b[i*W +: W], r, u);
                e.r[i] = r; e.u[i] = u;
            end
            sb4.push_back(e);
        end
        tick();
        in_valid4 = 1'b0;
    endtask

    task automatic drv4_rand(input bit push);
        logic [4*W-1:0] a, b;
        logic [W-1:0]   x;
        for (int i = 0; i < 4; i++) begin
            x = rnd_opnd();
            a[i*W +: W] = x;
            case ($urandom_range(0, 3))
                0:       b[i*W +: W] = x;
                1:       b[i*W +: W] = x ^ {3'b001, 63'd0};
                default: b[i*W +: W] = rnd_opnd();
            endcase
        end
        drv4(3'($urandom_range(0, 7)), a, b, push);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected: out_valid=1 with nothing pending, cycle %0d", cyc);
                end else begin
                    e = sb1.pop_front();
                    if (cyc != e.due || res1 !== e.r[0] || unord1 !== e.u[0]) begin
                        errors++;
                        $display("FAIL dut1_result: got cycle=%0d res=%b unord=%b, expected cycle=%0d res=%b unord=%b",
                                 cyc, res1, unord1, e.due, e.r[0], e.u[0]);
                    end
                    last1_r = e.r[0]; last1_u = e.u[0];
                end
            end else begin
                checks++;
                if (res1 !== last1_r || unord1 !== last1_u) begin
                    errors++;
                    $display("FAIL dut1_hold: got res=%b unord=%b expected res=%b unord=%b at cycle %0d",
                             res1, unord1, last1_r, last1_u, cyc);
                end
            end
            if (sb1.size() > 0 && sb1[0].due < cyc) begin
                checks++; errors++;
                e = sb1.pop_front();
                $display("FAIL dut1_missing: no output by cycle %0d, expected at cycle %0d", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid4) begin
                checks++;
                if (sb4.size() == 0) begin
                    errors++;
                    $display("FAIL dut4_unexpected: out_valid=1 with nothing pending, cycle %0d", cyc);
                end else begin
                    e = sb4.pop_front();
                    if (cyc != e.due || res4 !== e.r || unord4 !== e.u) begin
                        errors++;
                        $display("FAIL dut4_result: got cycle=%0d res=%b unord=%b, expected cycle=%0d res=%b unord=%b",
                                 cyc, res4, unord4, e.due, e.r, e.u);
                    end
                    last4_r = e.r; last4_u = e.u;
                end
            end else begin
                checks++;
                if (res4 !== last4_r || unord4 !== last4_u) begin
                    errors++;
                    $display("FAIL dut4_hold: got res=%b unord=%b expected res=%b unord=%b at cycle %0d",
                             res4, unord4, last4_r, last4_u, cyc);
                end
            end
            if (sb4.size() > 0 && sb4[0].due < cyc) begin
                checks++; errors++;
                e = sb4.pop_front();
                $display("FAIL dut4_missing: no output by cycle %0d, expected at cycle %0d", cyc, e.due);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0]   one, two, three, nan;
        logic [4*W-1:0] qa, qb;

        flush1 = 1'b0; in_valid1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        flush4 = 1'b0; in_valid4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        one   = from_real(1.0);
        two   = from_real(2.0);
        three = from_real(3.0);
        nan   = mk(2'b11, 1'b1, 11'h5a5, 52'h1234);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid1", {3'b0, out_valid1}, 4'h0);
        chk("reset_res1",       {3'b0, res1},       4'h0);
        chk("reset_unord1",     {3'b0, unord1},     4'h0);
        chk("reset_out_valid4", {3'b0, out_valid4}, 4'h0);
        chk("reset_res4",       res4,               4'h0);
        chk("reset_unord4",     unord4,             4'h0);

        // Release between edges; the first transaction rides the very next edge.
        rst = 1'b1;

        drv1(C_LT, one, two, 1'b1, 1'b1, 1'b0);
        drv1(C_GE, one, two, 1'b1, 1'b0, 1'b0);

        // +0 vs -0 with junk in the ignored fields.
        drv1(C_EQ, mk(2'b00, 1'b0, 11'd0, 52'd0), mk(2'b00, 1'b1, 11'h7ff, 52'h5), 1'b1, 1'b1, 1'b0);
        drv1(C_LE, mk(2'b00, 1'b0, 11'd0, 52'd0), mk(2'b00, 1'b1, 11'h7ff, 52'h5), 1'b1, 1'b1, 1'b0);
        drv1(C_GE, mk(2'b00, 1'b0, 11'd0, 52'd0), mk(2'b00, 1'b1, 11'h7ff, 52'h5), 1'b1, 1'b1, 1'b0);
        drv1(C_NE, mk(2'b00, 1'b0, 11'd0, 52'd0), mk(2'b00, 1'b1, 11'h7ff, 52'h5), 1'b1, 1'b0, 1'b0);

        // NaN against 3.0: everything false except NE; reserved op still flags unord.
        for (int k = 0; k < 6; k++)
            drv1(3'(k), nan, three, 1'b1, (k == 5) ? 1'b1 : 1'b0, 1'b1);
        drv1(3'b110, nan, three, 1'b1, 1'b0, 1'b1);
        drv1(3'b111, one, two, 1'b1, 1'b0, 1'b0);

        drv1(C_LT, mk(2'b10, 1'b1, 11'd0, 52'd0), from_real(-1.0e300), 1'b1, 1'b1, 1'b0);
        drv1(C_EQ, mk(2'b10, 1'b0, 11'h12, 52'd9), mk(2'b10, 1'b0, 11'd0, 52'd0), 1'b1, 1'b1, 1'b0);
        drv1(C_GT, from_real(-2.0), from_real(-1.0), 1'b1, 1'b0, 1'b0);
        drv1(C_LT, from_real(-2.0), from_real(-1.0), 1'b1, 1'b1, 1'b0);

        // Random single-lane traffic with occasional gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) tick();
            else drv1_model(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        end
        repeat (LAT1 + 2) tick();

        // 20 back-to-back four-lane transactions.
        for (int n = 0; n < 20; n++) drv4_rand(1'b1);
        repeat (LAT4 + 2) tick();

        // Flush with two transactions in flight plus a same-cycle input.
        drv4_rand(1'b1);
        drv4_rand(1'b0);
        drv4_rand(1'b0);
        flush4 = 1'b1;
        drv4_rand(1'b0);
        flush4 = 1'b0;
        repeat (LAT4 + 2) tick();
        drv4_rand(1'b1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) tick();
            else drv4_rand(1'b1);
        end
        repeat (LAT4 + 2) tick();

        // Leave nonzero results on both outputs before reset.
        drv1(C_LT, one, two, 1'b1, 1'b1, 1'b0);
        qa = {nan, three, one, one};
        qb = {one, one, three, two};
        drv4(C_NE, qa, qb, 1'b1);
        repeat (LAT4 + 2) tick();

        // Reset mid-stream with two transactions in flight on each instance.
        for (int n = 0; n < 2; n++) begin
            in_valid1 = 1'b1; op1 = C_LT; a1 = one; b1 = two;
            in_valid4 = 1'b1; op4 = C_NE; a4 = qa; b4 = qb;
            tick();
        end
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        #2;
        rst = 1'b0;
        last1_r = 1'b0; last1_u = 1'b0;
        last4_r = '0;   last4_u = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_out_valid1", {3'b0, out_valid1}, 4'h0);
        chk("midreset_res1",       {3'b0, res1},       4'h0);
        chk("midreset_unord1",     {3'b0, unord1},     4'h0);
        chk("midreset_out_valid4", {3'b0, out_valid4}, 4'h0);
        chk("midreset_res4",       res4,               4'h0);
        chk("midreset_unord4",     unord4,             4'h0);
        rst = 1'b1;
        repeat (LAT4 + 3) tick();

        drv1(C_GT, two, one, 1'b1, 1'b1, 1'b0);
        drv4_rand(1'b1);
        repeat (LAT4 + 2) tick();

        chk("drained_sb1", 4'(sb1.size()), 4'h0);
        chk("drained_sb4", 4'(sb4.size()), 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
